// File: rtl/id_stage_p.sv
// Decode stage of the 5-stage MIPS pipeline.
// It decodes the IF/ID instruction and reads a write-through register file.
// It sign-extends the immediate and detects load-use hazards.
// Results are registered into ID/EX, which supports hold, flush and bubble insertion.
module id_stage_p #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned HAZARD_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           if_id_instr,
    input  logic [XLEN-1:0]       if_id_npc,
    input  logic                  if_id_valid,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic                  mem_wb_reg_write,
    input  logic [XLEN-1:0]       wb_write_data,
    input  logic                  ex_hold,
    input  logic                  id_ex_flush,
    output logic                  stall_out,
    output logic                  id_ex_valid,
    output logic [1:0]            wb_ctl_out,
    output logic [2:0]            m_ctl_out,
    output logic                  reg_dst,
    output logic                  alu_src,
    output logic [1:0]            alu_op,
    output logic [XLEN-1:0]       npc_out,
    output logic [XLEN-1:0]       r_data1_out,
    output logic [XLEN-1:0]       r_data2_out,
    output logic [XLEN-1:0]       imm_out,
    output logic [REG_ADDR_W-1:0] rs_out,
    output logic [REG_ADDR_W-1:0] rt_out,
    output logic [REG_ADDR_W-1:0] rd_out
);

    localparam int unsigned NREGS = 2 ** REG_ADDR_W;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef struct packed {
        logic                  valid;
        logic                  regWrite;
        logic                  memToReg;
        logic                  branch;
        logic                  memRead;
        logic                  memWrite;
        logic                  regDst;
        logic                  aluSrc;
        logic [1:0]            aluOp;
        logic [XLEN-1:0]       npc;
        logic [XLEN-1:0]       rData1;
        logic [XLEN-1:0]       rData2;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } idEx_t;

    logic [XLEN-1:0]       regFile_q [NREGS];
    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rsIdx;
    logic [REG_ADDR_W-1:0] rtIdx;
    logic [REG_ADDR_W-1:0] rdIdx;
    logic [XLEN-1:0]       rsData;
    logic [XLEN-1:0]       rtData;
    logic                  usesRt;
    logic                  hazard;
    idEx_t                 decoded;
    idEx_t                 idEx_d;
    idEx_t                 idEx_q;

    assign opcode = if_id_instr[31:26];
    assign rsIdx  = if_id_instr[21 +: REG_ADDR_W];
    assign rtIdx  = if_id_instr[16 +: REG_ADDR_W];
    assign rdIdx  = if_id_instr[11 +: REG_ADDR_W];

    // Register file storage: entry 0 is never written, so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile_q[i] <= '0;
            end
        end else if (mem_wb_reg_write && (mem_wb_rd != '0)) begin
            regFile_q[mem_wb_rd] <= wb_write_data;
        end
    end

    // Read ports: a same-cycle writeback is forwarded so that WB and ID can share a cycle.
    always_comb begin
        rsData = regFile_q[rsIdx];
        rtData = regFile_q[rtIdx];
        if (mem_wb_reg_write && (mem_wb_rd == rsIdx)) rsData = wb_write_data;
        if (mem_wb_reg_write && (mem_wb_rd == rtIdx)) rtData = wb_write_data;
        if (rsIdx == '0) rsData = '0;
        if (rtIdx == '0) rtData = '0;
    end

    // Main decoder: unknown opcodes and empty IF/ID slots decode to a bubble with live data fields.
    always_comb begin
        decoded        = '0;
        decoded.npc    = if_id_npc;
        decoded.rData1 = rsData;
        decoded.rData2 = rtData;
        decoded.imm    = {{(XLEN-16){if_id_instr[15]}}, if_id_instr[15:0]};
        decoded.rs     = rsIdx;
        decoded.rt     = rtIdx;
        decoded.rd     = rdIdx;
        usesRt         = 1'b0;
        if (if_id_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    decoded.valid    = 1'b1;
                    decoded.regDst   = 1'b1;
                    decoded.aluOp    = 2'b10;
                    decoded.regWrite = 1'b1;
                    usesRt           = 1'b1;
                end
                OP_LW: begin
                    decoded.valid    = 1'b1;
                    decoded.aluSrc   = 1'b1;
                    decoded.memRead  = 1'b1;
                    decoded.regWrite = 1'b1;
                    decoded.memToReg = 1'b1;
                end
                OP_SW: begin
                    decoded.valid    = 1'b1;
                    decoded.aluSrc   = 1'b1;
                    decoded.memWrite = 1'b1;
                    usesRt           = 1'b1;
                end
                OP_BEQ: begin
                    decoded.valid    = 1'b1;
                    decoded.branch   = 1'b1;
                    decoded.aluOp    = 2'b01;
                    usesRt           = 1'b1;
                end
                OP_ADDI: begin
                    decoded.valid    = 1'b1;
                    decoded.aluSrc   = 1'b1;
                    decoded.regWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Load-use hazard: the load in ID/EX targets a register that the instruction in IF/ID reads.
    assign hazard = (HAZARD_EN != 0) && if_id_valid && idEx_q.valid && idEx_q.memRead &&
                    (idEx_q.rt != '0) &&
                    ((idEx_q.rt == rsIdx) || (usesRt && (idEx_q.rt == rtIdx)));

    assign stall_out = hazard | ex_hold;

    // ID/EX next state: a flush beats a hold, and a hold beats a hazard bubble.
    always_comb begin
        idEx_d = idEx_q;
        if (id_ex_flush) begin
            idEx_d = '0;
        end else if (ex_hold) begin
            idEx_d = idEx_q;
        end else if (hazard) begin
            idEx_d = '0;
        end else begin
            idEx_d = decoded;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            idEx_q <= '0;
        end else begin
            idEx_q <= idEx_d;
        end
    end

    assign id_ex_valid = idEx_q.valid;
    assign wb_ctl_out  = {idEx_q.regWrite, idEx_q.memToReg};
    assign m_ctl_out   = {idEx_q.branch, idEx_q.memRead, idEx_q.memWrite};
    assign reg_dst     = idEx_q.regDst;
    assign alu_src     = idEx_q.aluSrc;
    assign alu_op      = idEx_q.aluOp;
    assign npc_out     = idEx_q.npc;
    assign r_data1_out = idEx_q.rData1;
    assign r_data2_out = idEx_q.rData2;
    assign imm_out     = idEx_q.imm;
    assign rs_out      = idEx_q.rs;
    assign rt_out      = idEx_q.rt;
    assign rd_out      = idEx_q.rd;

endmodule

// File: tb/tb_id_stage_p.sv
// Directed bench for id_stage_p.
// It checks one instance with hazard detection enabled and one with it disabled.
// Both instances share their inputs.
module tb_id_stage_p;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdNpc;
    logic        ifIdValid;
    logic [4:0]  memWbRd;
    logic        memWbRegWrite;
    logic [31:0] wbWriteData;
    logic        exHold;
    logic        idExFlush;

    logic        stallOut, idExValid, regDst, aluSrc;
    logic [1:0]  wbCtl, aluOp;
    logic [2:0]  mCtl;
    logic [31:0] npcOut, rData1, rData2, immOut;
    logic [4:0]  rsOut, rtOut, rdOut;

    logic        nhStallOut, nhIdExValid, nhRegDst, nhAluSrc;
    logic [1:0]  nhWbCtl, nhAluOp;
    logic [2:0]  nhMCtl;
    logic [31:0] nhNpcOut, nhRData1, nhRData2, nhImmOut;
    logic [4:0]  nhRsOut, nhRtOut, nhRdOut;

    int totalChecks = 0;
    int badChecks   = 0;

    id_stage_p #(.XLEN(32), .REG_ADDR_W(5), .HAZARD_EN(1)) dut (
        .clk(clk), .rst(rst), .if_id_instr(ifIdInstr), .if_id_npc(ifIdNpc),
        .if_id_valid(ifIdValid), .mem_wb_rd(memWbRd), .mem_wb_reg_write(memWbRegWrite),
        .wb_write_data(wbWriteData), .ex_hold(exHold), .id_ex_flush(idExFlush),
        .stall_out(stallOut), .id_ex_valid(idExValid), .wb_ctl_out(wbCtl), .m_ctl_out(mCtl),
        .reg_dst(regDst), .alu_src(aluSrc), .alu_op(aluOp), .npc_out(npcOut),
        .r_data1_out(rData1), .r_data2_out(rData2), .imm_out(immOut),
        .rs_out(rsOut), .rt_out(rtOut), .rd_out(rdOut)
    );

    id_stage_p #(.XLEN(32), .REG_ADDR_W(5), .HAZARD_EN(0)) dutNoHaz (
        .clk(clk), .rst(rst), .if_id_instr(ifIdInstr), .if_id_npc(ifIdNpc),
        .if_id_valid(ifIdValid), .mem_wb_rd(memWbRd), .mem_wb_reg_write(memWbRegWrite),
        .wb_write_data(wbWriteData), .ex_hold(exHold), .id_ex_flush(idExFlush),
        .stall_out(nhStallOut), .id_ex_valid(nhIdExValid), .wb_ctl_out(nhWbCtl), .m_ctl_out(nhMCtl),
        .reg_dst(nhRegDst), .alu_src(nhAluSrc), .alu_op(nhAluOp), .npc_out(nhNpcOut),
        .r_data1_out(nhRData1), .r_data2_out(nhRData2), .imm_out(nhImmOut),
        .rs_out(nhRsOut), .rt_out(nhRtOut), .rd_out(nhRdOut)
    );

    // 10 ns free-running clock
    always #5 clk = ~clk;

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic [31:0] npc);
        ifIdInstr = instr;
        ifIdValid = valid;
        ifIdNpc   = npc;
    endtask

    task automatic setWriteback(input logic en, input logic [4:0] rd, input logic [31:0] data);
        memWbRegWrite = en;
        memWbRd       = rd;
        wbWriteData   = data;
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every data input nonzero, including a writeback attempt to r5
        rst = 1'b1;
        exHold = 1'b0;
        idExFlush = 1'b0;
        applyStimulus(rType(5'd1, 5'd2, 5'd3), 1'b1, 32'h0000_0040);
        setWriteback(1'b1, 5'd5, 32'h1234_5678);
        tick();
        tick();
        checkOutput("rst_valid", {63'd0, idExValid}, 64'd0);
        checkOutput("rst_wb", {62'd0, wbCtl}, 64'd0);
        checkOutput("rst_m", {61'd0, mCtl}, 64'd0);
        checkOutput("rst_aluop", {62'd0, aluOp}, 64'd0);
        checkOutput("rst_npc", {32'd0, npcOut}, 64'd0);
        checkOutput("rst_rdata1", {32'd0, rData1}, 64'd0);
        checkOutput("rst_imm", {32'd0, immOut}, 64'd0);
        checkOutput("rst_rd", {59'd0, rdOut}, 64'd0);

        rst = 1'b0;
        setWriteback(1'b0, 5'd0, 32'd0);
        for (int i = 1; i < 32; i++) begin
            applyStimulus(rType(5'(i), 5'(i), 5'd0), 1'b1, 32'd0);
            tick();
            checkOutput($sformatf("rst_reg%0d", i), {32'd0, rData1}, 64'd0);
        end

        // Load r1=5 and r2=7 through writeback while IF/ID is empty
        applyStimulus(32'd0, 1'b0, 32'd0);
        setWriteback(1'b1, 5'd1, 32'd5);
        tick();
        setWriteback(1'b1, 5'd2, 32'd7);
        tick();
        setWriteback(1'b0, 5'd0, 32'd0);

        // add $3,$1,$2
        applyStimulus(rType(5'd1, 5'd2, 5'd3), 1'b1, 32'h0000_0100);
        tick();
        checkOutput("add_rdata1", {32'd0, rData1}, 64'd5);
        checkOutput("add_rdata2", {32'd0, rData2}, 64'd7);
        checkOutput("add_rd", {59'd0, rdOut}, 64'd3);
        checkOutput("add_rs", {59'd0, rsOut}, 64'd1);
        checkOutput("add_rt", {59'd0, rtOut}, 64'd2);
        checkOutput("add_wb", {62'd0, wbCtl}, 64'b10);
        checkOutput("add_aluop", {62'd0, aluOp}, 64'b10);
        checkOutput("add_regdst", {63'd0, regDst}, 64'd1);
        checkOutput("add_alusrc", {63'd0, aluSrc}, 64'd0);
        checkOutput("add_m", {61'd0, mCtl}, 64'd0);
        checkOutput("add_valid", {63'd0, idExValid}, 64'd1);
        checkOutput("add_npc", {32'd0, npcOut}, 64'h100);

        // Same-cycle writeback to r4 is forwarded to the rs read
        applyStimulus(rType(5'd4, 5'd0, 5'd5), 1'b1, 32'h0000_0104);
        setWriteback(1'b1, 5'd4, 32'hDEAD_BEEF);
        tick();
        checkOutput("bypass_r4", {32'd0, rData1}, 64'hDEAD_BEEF);

        // A write to r0 is discarded, even through the bypass path
        applyStimulus(rType(5'd0, 5'd0, 5'd6), 1'b1, 32'h0000_0108);
        setWriteback(1'b1, 5'd0, 32'h1234_5678);
        tick();
        checkOutput("r0_bypass_rs", {32'd0, rData1}, 64'd0);
        checkOutput("r0_bypass_rt", {32'd0, rData2}, 64'd0);
        setWriteback(1'b0, 5'd0, 32'd0);
        tick();
        checkOutput("r0_after", {32'd0, rData1}, 64'd0);

        // Load-use: lw $2,0($1) followed by add $3,$2,$2
        applyStimulus(iType(6'h23, 5'd1, 5'd2, 16'h0000), 1'b1, 32'h0000_0200);
        tick();
        checkOutput("lw_m", {61'd0, mCtl}, 64'b010);
        checkOutput("lw_wb", {62'd0, wbCtl}, 64'b11);
        checkOutput("lw_alusrc", {63'd0, aluSrc}, 64'd1);
        checkOutput("lw_rdata1", {32'd0, rData1}, 64'd5);
        applyStimulus(rType(5'd2, 5'd2, 5'd3), 1'b1, 32'h0000_0204);
        #1;
        checkOutput("lu_stall", {63'd0, stallOut}, 64'd1);
        checkOutput("lu_nohaz_stall", {63'd0, nhStallOut}, 64'd0);
        tick();
        checkOutput("lu_bubble_valid", {63'd0, idExValid}, 64'd0);
        checkOutput("lu_bubble_wb", {62'd0, wbCtl}, 64'd0);
        checkOutput("lu_bubble_m", {61'd0, mCtl}, 64'd0);
        checkOutput("lu_bubble_aluop", {62'd0, aluOp}, 64'd0);
        checkOutput("lu_nohaz_valid", {63'd0, nhIdExValid}, 64'd1);
        checkOutput("lu_nohaz_rd", {59'd0, nhRdOut}, 64'd3);
        checkOutput("lu_stall_clear", {63'd0, stallOut}, 64'd0);
        tick();
        checkOutput("lu_add_valid", {63'd0, idExValid}, 64'd1);
        checkOutput("lu_add_rd", {59'd0, rdOut}, 64'd3);
        checkOutput("lu_add_rdata1", {32'd0, rData1}, 64'd7);
        checkOutput("lu_add_aluop", {62'd0, aluOp}, 64'b10);

        // ex_hold for three cycles freezes the add in ID/EX and stalls upstream
        applyStimulus(iType(6'h08, 5'd1, 5'd6, 16'h0010), 1'b1, 32'h0000_0300);
        exHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("hold_stall%0d", i), {63'd0, stallOut}, 64'd1);
            tick();
            checkOutput($sformatf("hold_valid%0d", i), {63'd0, idExValid}, 64'd1);
            checkOutput($sformatf("hold_rd%0d", i), {59'd0, rdOut}, 64'd3);
            checkOutput($sformatf("hold_rdata1_%0d", i), {32'd0, rData1}, 64'd7);
            checkOutput($sformatf("hold_aluop%0d", i), {62'd0, aluOp}, 64'b10);
        end

        // Flush wins over hold
        idExFlush = 1'b1;
        tick();
        checkOutput("flush_valid", {63'd0, idExValid}, 64'd0);
        checkOutput("flush_wb", {62'd0, wbCtl}, 64'd0);
        checkOutput("flush_aluop", {62'd0, aluOp}, 64'd0);
        checkOutput("flush_rdata1", {32'd0, rData1}, 64'd0);
        exHold = 1'b0;
        idExFlush = 1'b0;

        // addi with a negative immediate
        applyStimulus(iType(6'h08, 5'd1, 5'd6, 16'hFFFC), 1'b1, 32'h0000_0400);
        tick();
        checkOutput("addi_imm", {32'd0, immOut}, 64'hFFFF_FFFC);
        checkOutput("addi_alusrc", {63'd0, aluSrc}, 64'd1);
        checkOutput("addi_wb", {62'd0, wbCtl}, 64'b10);
        checkOutput("addi_aluop", {62'd0, aluOp}, 64'b00);
        checkOutput("addi_regdst", {63'd0, regDst}, 64'd0);
        checkOutput("addi_valid", {63'd0, idExValid}, 64'd1);

        // Unknown opcode 0x3F
        applyStimulus(iType(6'h3F, 5'd1, 5'd2, 16'h1234), 1'b1, 32'h0000_0404);
        tick();
        checkOutput("unk_valid", {63'd0, idExValid}, 64'd0);
        checkOutput("unk_ctl", {55'd0, wbCtl, mCtl, regDst, aluSrc, aluOp}, 64'd0);

        // sw $7,4($1) and beq $1,$2,-1
        applyStimulus(iType(6'h2B, 5'd1, 5'd7, 16'h0004), 1'b1, 32'h0000_0408);
        tick();
        checkOutput("sw_m", {61'd0, mCtl}, 64'b001);
        checkOutput("sw_alusrc", {63'd0, aluSrc}, 64'd1);
        checkOutput("sw_wb", {62'd0, wbCtl}, 64'd0);
        checkOutput("sw_imm", {32'd0, immOut}, 64'd4);
        applyStimulus(iType(6'h04, 5'd1, 5'd2, 16'hFFFF), 1'b1, 32'h0000_040C);
        tick();
        checkOutput("beq_m", {61'd0, mCtl}, 64'b100);
        checkOutput("beq_aluop", {62'd0, aluOp}, 64'b01);
        checkOutput("beq_imm", {32'd0, immOut}, 64'hFFFF_FFFF);
        checkOutput("beq_rdata2", {32'd0, rData2}, 64'd7);

        // sw reads rt, so lw $7 then sw $7 must stall
        applyStimulus(iType(6'h23, 5'd1, 5'd7, 16'h0000), 1'b1, 32'h0000_0500);
        tick();
        applyStimulus(iType(6'h2B, 5'd1, 5'd7, 16'h0000), 1'b1, 32'h0000_0504);
        #1;
        checkOutput("sw_rt_stall", {63'd0, stallOut}, 64'd1);
        tick();

        // addi does not read rt, so lw $8 then addi with rt=8 must not stall
        applyStimulus(iType(6'h23, 5'd1, 5'd8, 16'h0000), 1'b1, 32'h0000_0508);
        tick();
        applyStimulus(iType(6'h08, 5'd1, 5'd8, 16'h0001), 1'b1, 32'h0000_050C);
        #1;
        checkOutput("addi_rt_nostall", {63'd0, stallOut}, 64'd0);

        // A load into r0 never causes a hazard
        applyStimulus(iType(6'h23, 5'd1, 5'd0, 16'h0000), 1'b1, 32'h0000_0510);
        tick();
        applyStimulus(rType(5'd0, 5'd0, 5'd3), 1'b1, 32'h0000_0514);
        #1;
        checkOutput("lw_r0_nostall", {63'd0, stallOut}, 64'd0);
        tick();

        // Reset during a load-use stall clears the stall
        applyStimulus(iType(6'h23, 5'd1, 5'd2, 16'h0000), 1'b1, 32'h0000_0600);
        tick();
        applyStimulus(rType(5'd2, 5'd2, 5'd3), 1'b1, 32'h0000_0604);
        #1;
        checkOutput("pre_rst_stall", {63'd0, stallOut}, 64'd1);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_stall", {63'd0, stallOut}, 64'd0);
        checkOutput("mid_rst_valid", {63'd0, idExValid}, 64'd0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
